lfsr_checker: RTL
=================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter: lock_count_p, default 4, number of consecutive correct predictions needed to lock (legal range 1..15).
REQ-002 Parameter: err_thresh_p, default 3, number of consecutive mismatches while locked that drops lock (legal range 1..15).
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 valid_i  input  1  data_i holds a sequence word this cycle; no backpressure, so every valid word is consumed.
REQ-006 data_i  input  5  received LFSR word.
REQ-007 locked_o  output  1  registered; checker is tracking the sequence.
REQ-008 error_o  output  1  registered one-cycle pulse per mismatch while locked.
REQ-009 err_count_o  output  8  registered mismatch count, saturating.

Function
REQ-010 The sequence model SHALL be 5-bit Fibonacci x^5+x^3+1 (period 31): next(s) = {s[3:0], s[4]^s[2]}; 5'b00000 is illegal.
REQ-011 The FSM SHALL have two states: HUNT and LOCKED.
REQ-012 State: pred (5b), have_prev (1b), match_cnt (4b), bad_run (4b); cycles with valid_i=0 SHALL change no state and hold all outputs except error_o, which is 0.
REQ-013 HUNT, valid_i=1, data_i=0: match_cnt<=0, have_prev<=0, no reseed, error_o stays 0.
REQ-014 HUNT, valid_i=1, data_i!=0, and have_prev=0 or data_i!=pred: pred<=next(data_i), have_prev<=1, match_cnt<=0.
REQ-015 HUNT, valid_i=1, have_prev=1, data_i==pred: pred<=next(data_i), match_cnt<=match_cnt+1.
REQ-016 When the REQ-015 increment reaches lock_count_p: state<=LOCKED, locked_o<=1 on the same edge, bad_run<=0, match_cnt<=0.
REQ-017 LOCKED, valid_i=1, data_i==pred: pred<=next(pred), bad_run<=0, error_o<=0.
REQ-018 LOCKED, valid_i=1, data_i!=pred (including data_i=0): error_o<=1, err_count_o<=min(err_count_o+1,255), bad_run<=bad_run+1, pred<=next(pred) (flywheel; no reseed).
REQ-019 When the REQ-018 increment reaches err_thresh_p:
- state<=HUNT, locked_o<=0 on the same edge
- pred<=next(data_i) and have_prev<=1 if data_i!=0, else have_prev<=0
- match_cnt<=0
REQ-020 error_o SHALL never assert in HUNT; mismatches in HUNT SHALL NOT increment err_count_o.
REQ-021 err_count_o SHALL hold at 8'hFF once saturated; error_o still pulses on every later mismatch.
REQ-022 err_count_o SHALL clear only on reset; a lock loss does not clear it.
REQ-023 Latency SHALL be one cycle: outputs reflect the word sampled at the previous edge.

Reset
REQ-024 reset_i=1 at an edge SHALL force state=HUNT, locked_o=0, error_o=0, err_count_o=0, pred=0, have_prev=0, match_cnt=0, bad_run=0, regardless of valid_i or current state.
REQ-025 Reset SHALL take priority over every other update, including mid-lock or mid-hunt.
REQ-026 Word processing SHALL begin with the first valid_i=1 edge after reset_i deasserts.

Verification
REQ-027 Lock: after reset, feed back-to-back valid words 00001,00010,00100,01001,10010 -> locked_o=1 the cycle after 10010 is sampled; error_o=0 throughout; err_count_o=0.
REQ-028 Single error: locked and expecting 00101, send 00111, then 01011 -> error_o pulses once, err_count_o=1, locked_o stays 1 (flywheel prediction matches 01011).
REQ-029 Lock loss: while locked, send 3 consecutive wrong words -> error_o high 3 cycles, err_count_o+=3, locked_o=0 after the 3rd; then 5 consecutive correct words from the last word -> relock.
REQ-030 Gaps and zero: lock sequence interleaved with valid_i=0 cycles locks identically; a 00000 word in HUNT resets progress, so 5 fresh correct words are needed.
REQ-031 Saturation: 300 mismatches with relock cycles between bursts -> err_count_o stops at 255; error_o still pulses on later mismatches.
REQ-032 Reset mid-operation: assert reset_i while locked with err_count_o=7 -> next cycle locked_o=0, err_count_o=0, error_o=0.

Source files
------------

// File: rtl/lfsr_checker.sv
// lfsr_checker: locks onto a 5-bit x^5+x^3+1 Fibonacci LFSR word stream,
// flags mismatches while locked and keeps a saturating mismatch count.
module lfsr_checker #(
  parameter int unsigned lock_count_p = 4,
  parameter int unsigned err_thresh_p = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       valid_i,
  input  logic [4:0] data_i,
  output logic       locked_o,
  output logic       error_o,
  output logic [7:0] err_count_o
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [3:0] LockTarget   = 4'(lock_count_p);
  localparam logic [3:0] ThreshTarget = 4'(err_thresh_p);

  // Successor of a word in the period-31 sequence; zero never appears in it.
  function automatic logic [4:0] lfsrNext(input logic [4:0] s);
    return {s[3:0], s[4] ^ s[2]};
  endfunction

  state_t      r_state;
  logic [4:0]  r_pred;
  logic        r_havePrev;
  logic [3:0]  r_matchCnt;
  logic [3:0]  r_badRun;
  logic        r_error;
  logic [7:0]  r_errCount;

  state_t      w_stateNext;
  logic [4:0]  w_predNext;
  logic        w_havePrevNext;
  logic [3:0]  w_matchCntNext;
  logic [3:0]  w_badRunNext;
  logic        w_errorNext;
  logic [7:0]  w_errCountNext;

  logic [3:0]  w_matchInc;
  logic [3:0]  w_badInc;
  logic [7:0]  w_errCountSat;

  assign w_matchInc    = r_matchCnt + 4'd1;
  assign w_badInc      = r_badRun + 4'd1;
  assign w_errCountSat = (r_errCount == 8'hFF) ? 8'hFF : r_errCount + 8'd1;

  // Next-state and next-output decode; idle cycles keep everything but the error pulse.
  always_comb begin
    w_stateNext    = r_state;
    w_predNext     = r_pred;
    w_havePrevNext = r_havePrev;
    w_matchCntNext = r_matchCnt;
    w_badRunNext   = r_badRun;
    w_errorNext    = 1'b0;
    w_errCountNext = r_errCount;

    if (valid_i) begin
      case (r_state)
        HUNT: begin
          if (data_i == 5'd0) begin
            w_matchCntNext = 4'd0;
            w_havePrevNext = 1'b0;
          end else if (r_havePrev && (data_i == r_pred)) begin
            w_predNext = lfsrNext(data_i);
            if (w_matchInc == LockTarget) begin
              w_stateNext    = LOCKED;
              w_badRunNext   = 4'd0;
              w_matchCntNext = 4'd0;
            end else begin
              w_matchCntNext = w_matchInc;
            end
          end else begin
            w_predNext     = lfsrNext(data_i);
            w_havePrevNext = 1'b1;
            w_matchCntNext = 4'd0;
          end
        end

        LOCKED: begin
          if (data_i == r_pred) begin
            w_predNext   = lfsrNext(r_pred);
            w_badRunNext = 4'd0;
          end else begin
            w_errorNext    = 1'b1;
            w_errCountNext = w_errCountSat;
            w_badRunNext   = w_badInc;
            w_predNext     = lfsrNext(r_pred);
            if (w_badInc == ThreshTarget) begin
              w_stateNext    = HUNT;
              w_matchCntNext = 4'd0;
              if (data_i != 5'd0) begin
                w_predNext     = lfsrNext(data_i);
                w_havePrevNext = 1'b1;
              end else begin
                w_havePrevNext = 1'b0;
              end
            end
          end
        end

        default: begin
          w_stateNext = HUNT;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= HUNT;
      r_pred     <= 5'd0;
      r_havePrev <= 1'b0;
      r_matchCnt <= 4'd0;
      r_badRun   <= 4'd0;
      r_error    <= 1'b0;
      r_errCount <= 8'd0;
    end else begin
      r_state    <= w_stateNext;
      r_pred     <= w_predNext;
      r_havePrev <= w_havePrevNext;
      r_matchCnt <= w_matchCntNext;
      r_badRun   <= w_badRunNext;
      r_error    <= w_errorNext;
      r_errCount <= w_errCountNext;
    end
  end

  assign locked_o    = (r_state == LOCKED);
  assign error_o     = r_error;
  assign err_count_o = r_errCount;

endmodule
